// File: rtl/round_sat_pipe.sv
// Multi-lane round-then-saturate stage with a two-deep valid/ready pipeline.
// Stage 1 registers the rounded lanes, stage 2 registers the saturated output and flags.
module round_sat_pipe #(
   parameter int IWID = 16,
   parameter int OWID = 8,
   parameter int FRAC = 8,
   parameter int NCH  = 2,
   parameter int SAT  = 1,
   parameter int CNTW = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [NCH*IWID-1:0]  i_data,
   input  logic [1:0]           i_mode,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [NCH*OWID-1:0]  o_data,
   output logic [NCH-1:0]       o_ovf,
   input  logic                 i_clr,
   output logic [CNTW-1:0]      o_ovf_cnt
);

   // One guard bit above the quotient so the rounding increment cannot wrap.
   localparam int RW = IWID - FRAC + 1;
   localparam logic [CNTW:0] CNT_MAX = {1'b0, {CNTW{1'b1}}};

   function automatic logic [CNTW:0] popcnt(input logic [NCH-1:0] v);
      logic [CNTW:0] c;
      c = {(CNTW+1){1'b0}};
      for (int i = 0; i < NCH; i++) begin
         c = c + {{CNTW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   logic                 w_s1_load;
   logic                 w_s2_load;
   logic [NCH*RW-1:0]    w_rnd;
   logic [NCH*OWID-1:0]  w_sat;
   logic [NCH-1:0]       w_ovf;
   logic [CNTW:0]        w_sum;

   logic                 r_s1_valid;
   logic [NCH*RW-1:0]    r_s1_rnd;
   logic                 r_out_valid;
   logic [NCH*OWID-1:0]  r_out_data;
   logic [NCH-1:0]       r_out_ovf;
   logic [CNTW-1:0]      r_cnt;

   assign w_s2_load = !r_out_valid || i_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign o_ready   = w_s1_load;
   assign o_valid   = r_out_valid;
   assign o_data    = r_out_data;
   assign o_ovf     = r_out_ovf;
   assign o_ovf_cnt = r_cnt;

   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_lane
         logic [IWID-1:0] w_x;
         logic [RW-1:0]   w_q;
         logic            w_inc;
         logic [RW-1:0]   w_r;
         logic [OWID-1:0] w_lane;

         assign w_x = i_data[k*IWID +: IWID];

         if (FRAC == 0) begin : g_nofrac
            assign w_q   = {w_x[IWID-1], w_x};
            assign w_inc = 1'b0;
         end else begin : g_frac
            localparam int unsigned HALF_I = 32'd1 << (FRAC-1);
            localparam logic [FRAC-1:0] HALF = HALF_I[FRAC-1:0];
            logic [FRAC-1:0] w_f;

            assign w_q = {w_x[IWID-1], w_x[IWID-1:FRAC]};
            assign w_f = w_x[FRAC-1:0];

            // Rounding increment selected by the beat's mode.
            always_comb begin
               case (i_mode)
                  2'd0:    w_inc = 1'b0;
                  2'd1:    w_inc = (w_f >= HALF);
                  2'd2:    w_inc = (w_f > HALF) || ((w_f == HALF) && !w_x[IWID-1]);
                  2'd3:    w_inc = (w_f > HALF) || ((w_f == HALF) && w_q[0]);
                  default: w_inc = 1'b0;
               endcase
            end
         end

         assign w_rnd[k*RW +: RW] = w_q + {{(RW-1){1'b0}}, w_inc};
         assign w_r = r_s1_rnd[k*RW +: RW];

         if (RW <= OWID) begin : g_ext
            assign w_lane   = OWID'($signed(w_r));
            assign w_ovf[k] = 1'b0;
         end else begin : g_sat
            logic [RW-OWID:0] w_top;
            // In range exactly when every bit from the output sign upward agrees.
            assign w_top    = w_r[RW-1:OWID-1];
            assign w_ovf[k] = !((&w_top) || !(|w_top));

            // Clamp to the signed output range, or keep the low bits when wrapping.
            always_comb begin
               if (w_ovf[k] && (SAT != 0)) begin
                  w_lane = w_r[RW-1] ? {1'b1, {(OWID-1){1'b0}}} : {1'b0, {(OWID-1){1'b1}}};
               end else begin
                  w_lane = w_r[OWID-1:0];
               end
            end
         end

         assign w_sat[k*OWID +: OWID] = w_lane;
      end
   endgenerate

   // Two pipeline stages; each loads only when its downstream slot frees up.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_rnd    <= {(NCH*RW){1'b0}};
         r_out_valid <= 1'b0;
         r_out_data  <= {(NCH*OWID){1'b0}};
         r_out_ovf   <= {NCH{1'b0}};
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
               r_s1_rnd <= w_rnd;
            end
         end
         if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_data <= w_sat;
               r_out_ovf  <= w_ovf;
            end
         end
      end
   end

   assign w_sum = {1'b0, r_cnt} + popcnt(r_out_ovf);

   // Saturating overflow counter; clear has priority over a same-cycle count.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_cnt <= {CNTW{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {CNTW{1'b0}};
      end else if (r_out_valid && i_ready) begin
         r_cnt <= (w_sum > CNT_MAX) ? CNT_MAX[CNTW-1:0] : w_sum[CNTW-1:0];
      end
   end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Scoreboard bench for round_sat_pipe: a saturating instance and a wrapping,
// 3-bit-counter instance share the same stimulus and are checked in lockstep.
module tb_round_sat_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic        i_clr = 1'b0;
   logic [1:0]  i_mode = 2'd0;
   logic [31:0] i_data = 32'h0;

   logic        o_ready, o_valid;
   logic [15:0] o_data;
   logic [1:0]  o_ovf;
   logic [15:0] o_ovf_cnt;
   logic        o_ready_w, o_valid_w;
   logic [15:0] o_data_w;
   logic [1:0]  o_ovf_w;
   logic [2:0]  o_ovf_cnt_w;

   int checks = 0;
   int fails  = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  ovf;
      logic [15:0] w;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   round_sat_pipe u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_ovf(o_ovf), .i_clr(i_clr), .o_ovf_cnt(o_ovf_cnt)
   );

   round_sat_pipe #(.SAT(0), .CNTW(3)) u_wrap (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_w),
      .i_data(i_data), .i_mode(i_mode), .o_valid(o_valid_w), .i_ready(i_ready),
      .o_data(o_data_w), .o_ovf(o_ovf_w), .i_clr(i_clr), .o_ovf_cnt(o_ovf_cnt_w)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pop the oldest expected beat on every output handshake.
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL sb_pop: output beat %h arrived, expected no beat", o_data);
         end else begin
            mon_e = sb.pop_front();
            chk("data", {16'h0, o_data}, {16'h0, mon_e.d});
            chk("ovf", {30'h0, o_ovf}, {30'h0, mon_e.ovf});
            chk("wrap_data", {16'h0, o_data_w}, {16'h0, mon_e.w});
            chk("wrap_ovf", {30'h0, o_ovf_w}, {30'h0, mon_e.ovf});
            chk("wrap_valid", {31'h0, o_valid_w}, 32'd1);
         end
      end
   end

   // Issue one beat and push its hand-computed result; returns 1 ns after acceptance.
   task automatic send(input logic [15:0] x0, input logic [15:0] x1, input logic [1:0] m,
                       input logic [7:0] s0, input logic [7:0] s1, input logic [1:0] ov,
                       input logic [7:0] w0, input logic [7:0] w1);
      logic acc;
      int   n;
      exp_t e;
      e.d   = {s1, s0};
      e.ovf = ov;
      e.w   = {w1, w0};
      sb.push_back(e);
      i_valid = 1'b1;
      i_data  = {x1, x0};
      i_mode  = m;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         fails++;
         $display("FAIL send_timeout: beat %h not accepted, expected acceptance within 50 cycles", {x1, x0});
      end
      i_valid = 1'b0;
      i_data  = 32'hDEAD_BEEF;
      i_mode  = 2'd3;
   endtask

   // Wait for the pipeline to empty; returns 1 ns after a rising edge.
   task automatic drain();
      int n;
      repeat (3) @(negedge clk);
      n = 0;
      while (o_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (o_valid) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: o_valid still 1, expected 0 within 40 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_o_valid", {31'h0, o_valid}, 32'd0);
      chk("rst_o_ready", {31'h0, o_ready}, 32'd1);
      chk("rst_o_data", {16'h0, o_data}, 32'd0);
      chk("rst_o_ovf", {30'h0, o_ovf}, 32'd0);
      chk("rst_cnt", {16'h0, o_ovf_cnt}, 32'd0);
      chk("rst_cnt_w", {29'h0, o_ovf_cnt_w}, 32'd0);
      rst_n = 1'b1;

      // Tie handling across all four modes.
      send(16'h0280, 16'h0380, 2'd3, 8'h02, 8'h04, 2'b00, 8'h02, 8'h04);
      send(16'hFD80, 16'h0281, 2'd0, 8'hFD, 8'h02, 2'b00, 8'hFD, 8'h02);
      send(16'hFD80, 16'h0281, 2'd1, 8'hFE, 8'h03, 2'b00, 8'hFE, 8'h03);
      send(16'hFD80, 16'h0281, 2'd2, 8'hFD, 8'h03, 2'b00, 8'hFD, 8'h03);
      send(16'hFD80, 16'h0281, 2'd3, 8'hFE, 8'h03, 2'b00, 8'hFE, 8'h03);
      send(16'h0080, 16'hFF80, 2'd2, 8'h01, 8'hFF, 2'b00, 8'h01, 8'hFF);
      send(16'h0080, 16'hFF80, 2'd1, 8'h01, 8'h00, 2'b00, 8'h01, 8'h00);
      send(16'h0080, 16'hFF80, 2'd3, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);

      // Range limits: saturate versus wrap.
      send(16'h7FC0, 16'h8000, 2'd1, 8'h7F, 8'h80, 2'b01, 8'h80, 8'h80);
      send(16'h8000, 16'h8000, 2'd0, 8'h80, 8'h80, 2'b00, 8'h80, 8'h80);
      send(16'h7F7F, 16'h8000, 2'd1, 8'h7F, 8'h80, 2'b00, 8'h7F, 8'h80);
      send(16'h7FC0, 16'h7FFF, 2'd1, 8'h7F, 8'h7F, 2'b11, 8'h80, 8'h80);
      drain();
      chk("cnt_after_sat", {16'h0, o_ovf_cnt}, 32'd3);
      chk("cnt_w_after_sat", {29'h0, o_ovf_cnt_w}, 32'd3);

      // Backpressure: six beats with i_ready low for three cycles.
      fork
         begin
            for (int k = 1; k <= 6; k++) begin
               send({8'(k), 8'h00}, {8'(k), 8'h40}, 2'd0, 8'(k), 8'(k), 2'b00, 8'(k), 8'(k));
            end
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            i_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               chk("bp_o_ready", {31'h0, o_ready}, 32'd0);
               chk("bp_hold_data", {16'h0, o_data}, 32'h0101);
            end
            @(posedge clk);
            #1;
            i_ready = 1'b1;
         end
      join
      drain();

      // Mode changes on every beat.
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 1) send(16'h0180, 16'h0180, 2'd3, 8'h02, 8'h02, 2'b00, 8'h02, 8'h02);
         else            send(16'h0180, 16'h0180, 2'd0, 8'h01, 8'h01, 2'b00, 8'h01, 8'h01);
      end
      drain();

      // Overflow counter: clear, accumulate, clear-wins, clamp.
      i_clr = 1'b1;
      @(posedge clk);
      #1;
      i_clr = 1'b0;
      chk("cnt_clr", {16'h0, o_ovf_cnt}, 32'd0);
      chk("cnt_w_clr", {29'h0, o_ovf_cnt_w}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         send(16'h7FC0, 16'h7FFF, 2'd1, 8'h7F, 8'h7F, 2'b11, 8'h80, 8'h80);
      end
      drain();
      chk("cnt_6", {16'h0, o_ovf_cnt}, 32'd6);
      chk("cnt_w_6", {29'h0, o_ovf_cnt_w}, 32'd6);
      i_clr = 1'b1;
      send(16'h7FC0, 16'h7FFF, 2'd1, 8'h7F, 8'h7F, 2'b11, 8'h80, 8'h80);
      drain();
      i_clr = 1'b0;
      chk("cnt_clr_wins", {16'h0, o_ovf_cnt}, 32'd0);
      chk("cnt_w_clr_wins", {29'h0, o_ovf_cnt_w}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         send(16'h7FC0, 16'h7FFF, 2'd1, 8'h7F, 8'h7F, 2'b11, 8'h80, 8'h80);
      end
      drain();
      chk("cnt_10", {16'h0, o_ovf_cnt}, 32'd10);
      chk("cnt_w_clamp", {29'h0, o_ovf_cnt_w}, 32'd7);

      // Reset with two beats held.
      i_ready = 1'b0;
      send(16'h0100, 16'h0200, 2'd0, 8'h01, 8'h02, 2'b00, 8'h01, 8'h02);
      send(16'h0300, 16'h0400, 2'd0, 8'h03, 8'h04, 2'b00, 8'h03, 8'h04);
      chk("held_o_ready", {31'h0, o_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      chk("mid_rst_o_valid", {31'h0, o_valid}, 32'd0);
      chk("mid_rst_cnt", {16'h0, o_ovf_cnt}, 32'd0);
      chk("mid_rst_o_ready", {31'h0, o_ready}, 32'd1);
      chk("mid_rst_o_data", {16'h0, o_data}, 32'd0);
      chk("mid_rst_cnt_w", {29'h0, o_ovf_cnt_w}, 32'd0);
      rst_n   = 1'b1;
      i_ready = 1'b1;

      // First beat after reset: o_valid two cycles after acceptance.
      send(16'h0500, 16'h0600, 2'd0, 8'h05, 8'h06, 2'b00, 8'h05, 8'h06);
      @(negedge clk);
      chk("lat_cycle1_o_valid", {31'h0, o_valid}, 32'd0);
      @(negedge clk);
      chk("lat_cycle2_o_valid", {31'h0, o_valid}, 32'd1);
      @(posedge clk);
      #1;
      drain();
      chk("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
